// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command decoder: FSM state encoding,
// error codes and the byte width.
package uart_cmd_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ADDR = 2'd1,
    ST_CHECK     = 2'd2,
    ST_HOLD      = 2'd3
  } state_t;

  typedef logic [1:0] err_t;

  localparam err_t ERR_NONE    = 2'd0;
  localparam err_t ERR_OP      = 2'd1;
  localparam err_t ERR_ADDR    = 2'd2;
  localparam err_t ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/inter_byte_timer.sv
// Saturating inter-byte cycle counter; expired is high once the count reaches
// TIMEOUT_CYCLES-1 and stays high until the next clear.
module inter_byte_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Two-byte (opcode, address) UART command decoder with valid/ready output.
// Define CMD_TIMEOUT_EN to build the inter-byte timeout between the two bytes.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_IDLE      | waiting for the opcode byte
//   ST_WAIT_ADDR | opcode latched, waiting for the address byte
//   ST_CHECK     | one cycle range check of opcode then address
//   ST_HOLD      | command presented on cmd_valid until cmd_ready
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int NUM_CMDS       = 8,
  parameter int ADDR_MAX       = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_done,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [BYTE_W-1:0] cmd_op,
  output logic [BYTE_W-1:0] cmd_addr,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  if (CLK_HZ < 1 || TIMEOUT_CYCLES < 1 || NUM_CMDS < 1 || ADDR_MAX < 0) begin : g_param_check
    $error("uart_cmd_decoder: illegal parameter value");
  end

  state_t state;
  logic   rx_done_q;
  logic   armed;
  logic   byte_evt;
  logic   timed_out;
  logic   op_bad;
  logic   addr_bad;

  // armed blocks an rx_done that is already high when reset releases
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_done_q <= 1'b0;
      armed     <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      armed     <= 1'b1;
    end
  end

  assign byte_evt = armed & rx_done & ~rx_done_q;
  assign op_bad   = int'(cmd_op) >= NUM_CMDS;
  assign addr_bad = int'(cmd_addr) > ADDR_MAX;

`ifdef CMD_TIMEOUT_EN
  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  assign timer_clear  = (state == ST_IDLE) && byte_evt;
  assign timer_enable = (state == ST_WAIT_ADDR);

  inter_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  assign timed_out = timer_expired;
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_addr  <= '0;
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      err_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (byte_evt) begin
            cmd_op <= rx_data;
            state  <= ST_WAIT_ADDR;
          end
        end
        ST_WAIT_ADDR: begin
          if (byte_evt) begin
            cmd_addr <= rx_data;
            state    <= ST_CHECK;
          end else if (timed_out) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
            state     <= ST_IDLE;
          end
        end
        ST_CHECK: begin
          // a range error and a dropped byte in the same cycle share one pulse
          if (op_bad) begin
            err_valid <= 1'b1;
            err_code  <= ERR_OP;
            state     <= ST_IDLE;
          end else if (addr_bad) begin
            err_valid <= 1'b1;
            err_code  <= ERR_ADDR;
            state     <= ST_IDLE;
          end else begin
            cmd_valid <= 1'b1;
            state     <= ST_HOLD;
            if (byte_evt) begin
              err_valid <= 1'b1;
              err_code  <= ERR_TIMEOUT;
            end
          end
        end
        ST_HOLD: begin
          if (byte_evt) begin
            err_valid <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder; covers the timeout path when built
// with CMD_TIMEOUT_EN and the wait-forever behaviour otherwise.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [7:0] cmd_op;
  logic [7:0] cmd_addr;
  logic       err_valid;
  logic [1:0] err_code;

  int n_chk = 0;
  int n_bad = 0;

  int         hs_cnt = 0;
  int         err_cnt = 0;
  int         valid_cnt = 0;
  logic [7:0] hs_op = 8'h00;
  logic [7:0] hs_addr = 8'h00;
  logic [1:0] err_seen = 2'd0;

  int h0, e0, n;

  always #5 clk = ~clk;

  uart_cmd_decoder #(
    .CLK_HZ        (50_000_000),
    .TIMEOUT_CYCLES(100),
    .NUM_CMDS      (8),
    .ADDR_MAX      (31)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .err_valid(err_valid),
    .err_code (err_code)
  );

  // inputs change 2 time units after posedge, so the negedge view is stable
  always @(negedge clk) begin
    if (reset_n) begin
      if (cmd_valid) valid_cnt++;
      if (cmd_valid && cmd_ready) begin
        hs_cnt++;
        hs_op   = cmd_op;
        hs_addr = cmd_addr;
      end
      if (err_valid) begin
        err_cnt++;
        err_seen = err_code;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // rx_done held high for two cycles so a long strobe must count once
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic run_frame(input string tag, input logic [7:0] op, input logic [7:0] addr,
                           input bit ok, input logic [1:0] code);
    int hb, eb, vb;
    hb = hs_cnt;
    eb = err_cnt;
    vb = valid_cnt;
    cmd_ready = 1'b1;
    send_byte(op);
    send_byte(addr);
    tick();
    chk({tag, "_hs"}, hs_cnt - hb, ok ? 1 : 0);
    chk({tag, "_err"}, err_cnt - eb, ok ? 0 : 1);
    chk({tag, "_vld"}, valid_cnt - vb, ok ? 1 : 0);
    if (ok) begin
      chk({tag, "_op"}, hs_op, op);
      chk({tag, "_addr"}, hs_addr, addr);
    end else begin
      chk({tag, "_code"}, err_seen, code);
    end
  endtask

  initial begin
    // reset with rx_done already high: must not become an opcode
    reset_n   = 1'b0;
    rx_done   = 1'b1;
    rx_data   = 8'h07;
    cmd_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_op", cmd_op, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_code", err_code, 0);
    reset_n = 1'b1;
    repeat (3) tick();
    rx_done = 1'b0;
    tick();

    // latency: edge consumed at P0, cmd_valid visible after P1, gone after P2
    send_byte(8'h03);
    rx_data = 8'h10;
    rx_done = 1'b1;
    tick();
    chk("lat_p0_valid", cmd_valid, 0);
    tick();
    chk("lat_p1_valid", cmd_valid, 1);
    chk("lat_p1_op", cmd_op, 8'h03);
    chk("lat_p1_addr", cmd_addr, 8'h10);
    tick();
    chk("lat_p2_valid", cmd_valid, 0);
    rx_done = 1'b0;
    tick();
    chk("lat_hs", hs_cnt, 1);
    chk("lat_err", err_cnt, 0);

    run_frame("bad_op", 8'h09, 8'h05, 1'b0, 2'd1);
    run_frame("bad_addr", 8'h02, 8'h40, 1'b0, 2'd2);
    run_frame("both_bad", 8'h0A, 8'h40, 1'b0, 2'd1);
    run_frame("edge_ok", 8'h07, 8'h1F, 1'b1, 2'd0);
    run_frame("op8", 8'h08, 8'h00, 1'b0, 2'd1);
    run_frame("addr32", 8'h00, 8'h20, 1'b0, 2'd2);

`ifdef CMD_TIMEOUT_EN
    rx_data = 8'h01;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    n = 0;
    while (n < 200 && !err_valid) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 100);
    chk("to_code", err_code, 2'd3);
    tick();
    chk("to_pulse_w", err_valid, 0);
    run_frame("to_after", 8'h01, 8'h02, 1'b1, 2'd0);
`else
    e0 = err_cnt;
    h0 = hs_cnt;
    rx_data = 8'h01;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    repeat (150) tick();
    chk("nto_err", err_cnt - e0, 0);
    send_byte(8'h02);
    tick();
    chk("nto_hs", hs_cnt - h0, 1);
    chk("nto_op", hs_op, 8'h01);
    chk("nto_addr", hs_addr, 8'h02);
`endif

    // overrun during HOLD leaves the held command untouched
    cmd_ready = 1'b0;
    h0 = hs_cnt;
    e0 = err_cnt;
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (5) tick();
    send_byte(8'h55);
    chk("hold_err", err_cnt - e0, 1);
    chk("hold_code", err_seen, 2'd3);
    chk("hold_valid", cmd_valid, 1);
    chk("hold_op", cmd_op, 8'h01);
    chk("hold_addr", cmd_addr, 8'h02);
    repeat (9) tick();
    chk("hold_no_hs", hs_cnt - h0, 0);
    cmd_ready = 1'b1;
    tick();
    chk("hold_release", cmd_valid, 0);
    chk("hold_hs", hs_cnt - h0, 1);
    chk("hold_hs_op", hs_op, 8'h01);
    chk("hold_hs_addr", hs_addr, 8'h02);

    // byte arriving on the handshake cycle is dropped and flagged
    cmd_ready = 1'b0;
    send_byte(8'h04);
    send_byte(8'h05);
    tick();
    h0 = hs_cnt;
    e0 = err_cnt;
    rx_data   = 8'h06;
    rx_done   = 1'b1;
    cmd_ready = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
    chk("coinc_err", err_cnt - e0, 1);
    chk("coinc_code", err_seen, 2'd3);
    chk("coinc_hs", hs_cnt - h0, 1);
    chk("coinc_hs_op", hs_op, 8'h04);
    run_frame("after_coinc", 8'h05, 8'h06, 1'b1, 2'd0);

    // reset between byte 1 and byte 2
    send_byte(8'h03);
    e0 = err_cnt;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_op", cmd_op, 0);
    chk("mid_rst_valid", cmd_valid, 0);
    chk("mid_rst_err_code", err_code, 0);
    chk("mid_rst_err_valid", err_valid, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_rst_no_err", err_cnt - e0, 0);
    run_frame("post_rst", 8'h04, 8'h01, 1'b1, 2'd0);

    // reset during HOLD discards the command silently
    cmd_ready = 1'b0;
    send_byte(8'h02);
    send_byte(8'h03);
    tick();
    chk("hrst_pre_valid", cmd_valid, 1);
    h0 = hs_cnt;
    e0 = err_cnt;
    reset_n = 1'b0;
    #1;
    chk("hrst_valid", cmd_valid, 0);
    chk("hrst_op", cmd_op, 0);
    tick();
    reset_n = 1'b1;
    tick();
    cmd_ready = 1'b1;
    repeat (3) tick();
    chk("hrst_no_hs", hs_cnt - h0, 0);
    chk("hrst_no_err", err_cnt - e0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, system clock frequency.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, the maximum number of cycles allowed between command byte and address byte.
REQ-003 SHALL have parameter NUM_CMDS, default 8, number of legal opcodes (0 to NUM_CMDS-1).
REQ-004 SHALL have parameter ADDR_MAX, default 31, highest legal address.
REQ-005 clk  input  1  system clock, rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 rx_done  input  1  byte-received strobe from the UART receiver; held high for at least 1 cycle, and only its rising edge counts.
REQ-008 rx_data  input  8  received byte, stable while rx_done is high.
REQ-009 cmd_ready  input  1  downstream accepts the command.
REQ-010 cmd_valid  output  1  decoded command available.
REQ-011 cmd_op  output  8  opcode.
REQ-012 cmd_addr  output  8  address.
REQ-013 err_valid  output  1  one-cycle error pulse.
REQ-014 err_code  output  2  error type: 1 = bad opcode, 2 = bad address, 3 = timeout or overrun; held until the next error.

Function
REQ-015 SHALL detect the rising edge of rx_done with a registered copy, and SHALL treat each edge as exactly one byte event.
REQ-016 SHALL implement a four-state FSM: IDLE, WAIT_ADDR, CHECK, HOLD.
REQ-017 IDLE: on a byte event, latch rx_data into cmd_op and go to WAIT_ADDR.
REQ-018 WAIT_ADDR: on a byte event, latch cmd_addr and go to CHECK; on timeout, pulse err_valid with err_code=3 and go to IDLE.
REQ-019 CHECK (1 cycle): if cmd_op ≥ NUM_CMDS, error 1 and go to IDLE; otherwise, if cmd_addr > ADDR_MAX, error 2 and go to IDLE; otherwise assert cmd_valid and go to HOLD.
REQ-020 Opcode checking SHALL take priority over address checking when both fields are illegal.
REQ-021 HOLD: cmd_valid, cmd_op and cmd_addr SHALL remain stable until cmd_ready is sampled high.
REQ-022 When cmd_valid and cmd_ready are both high, the handshake completes: cmd_valid SHALL deassert on the next cycle and the FSM SHALL return to IDLE.
REQ-023 If cmd_ready is already high on entry to HOLD, the handshake SHALL complete in that same HOLD cycle.
REQ-024 Latency: byte-2 edge detected → cmd_valid high is 2 cycles.
REQ-025 A byte event in CHECK or HOLD SHALL be dropped, with err_valid and err_code=3 pulsed, without disturbing the held command.
REQ-026 A byte event coincident with handshake completion SHALL also be dropped and flagged as in REQ-025.
REQ-027 The timeout counter SHALL clear on entry to WAIT_ADDR and saturate; timeout is reached when the count equals TIMEOUT_CYCLES-1.
REQ-028 err_valid SHALL be high for exactly one cycle per error, and errors SHALL never assert cmd_valid.

Reset
REQ-029 While reset_n is low: FSM=IDLE, cmd_valid=0, cmd_op=0, cmd_addr=0, err_valid=0, err_code=0, counter=0, edge register=0.
REQ-030 Reset asserted mid-frame or during HOLD SHALL discard the partial or held command with no error pulse.
REQ-031 After reset_n deasserts, an rx_done already high SHALL NOT produce a byte event.

Configuration
REQ-032 The macro CMD_TIMEOUT_EN SHALL control the inter-byte timeout.
REQ-033 With CMD_TIMEOUT_EN defined, the timeout counter and the REQ-018 timeout path SHALL exist.
REQ-034 Without CMD_TIMEOUT_EN, no counter SHALL be synthesised, WAIT_ADDR SHALL wait indefinitely, and err_code=3 SHALL signal overrun only.

Structure
REQ-035 Shared package uart_cmd_pkg SHALL hold the FSM state encoding, the err_code constants (ERR_NONE, ERR_OP, ERR_ADDR, ERR_TIMEOUT) and the byte width.
REQ-036 One sub-module, inter_byte_timer (clear, enable, expired), SHALL implement the timeout counter and SHALL only be instantiated under CMD_TIMEOUT_EN.
REQ-037 All other logic SHALL be in uart_cmd_decoder; target size is 120–400 lines of RTL.

Verification
REQ-038 Bytes 0x03 then 0x10, cmd_ready=1 → one cmd_valid with op=0x03, addr=0x10, 2 cycles after the second edge, and no err_valid.
REQ-039 Bytes 0x09 then 0x05 → err_valid pulse with err_code=1, no cmd_valid, FSM back in IDLE.
REQ-040 Bytes 0x02 then 0x40 → err_code=2; bytes 0x0A then 0x40 → err_code=1 (opcode priority).
REQ-041 With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100, byte 0x01 then no byte for 100 cycles → err_code=3; a following frame 0x01, 0x02 decodes correctly.
REQ-042 Frame 0x01, 0x02 with cmd_ready=0 for 20 cycles, byte 0x55 injected during HOLD → err_code=3 pulse, op/addr stay 0x01/0x02, then handshake completes when cmd_ready rises.
REQ-043 reset_n pulsed low between byte 1 and byte 2 → all outputs 0, and the next byte is taken as an opcode.
